// File: rtl/la_capture_pkg.sv
// Shared types and widths for the logic-analyzer capture buffer.
package la_capture_pkg;

    localparam int TS_W = 32;
    localparam int LA_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/la_capture_mem.sv
// Sample store for la_capture: simple dual-port RAM, synchronous write and
// registered read with one cycle of latency. The array itself has no reset.
module la_capture_mem
    import la_capture_pkg::*;
#(
    parameter int WIDTH = LA_W,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read register only updates on i_re, so a stalled consumer sees stable data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/la_capture.sv
// Trigger-qualified LA capture buffer with valid/ready readout.
// Optional cycle timestamp of the trigger sample: define LA_CAPTURE_TIMESTAMP_EN.
module la_capture
    import la_capture_pkg::*;
#(
    parameter int WIDTH = LA_W,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] la_dat,
    input  logic             arm,
    input  logic             abort,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    output logic             busy,
    output logic             done,
    output cap_state_t       state,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic [TS_W-1:0]  trig_time
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cap_state_t       r_state;
    cap_state_t       w_next;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_rd_idx;
    logic             r_rd_valid;
    logic             w_hit;
    logic             w_arm_ok;
    logic             w_hs;
    logic             w_last;
    logic             w_cap_end;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic             w_re;
    logic [WIDTH-1:0] w_mem_q;

    assign w_hit        = ((la_dat ^ trig_value) & trig_mask) == '0;
    assign w_arm_ok     = arm && (r_state == IDLE || r_state == DONE);
    assign w_hs         = r_rd_valid && rd_ready;
    assign w_last       = r_rd_valid && (r_rd_idx == AW'(DEPTH - 1));
    assign w_count_next = r_count + CW'(1);
    assign w_cap_end    = (r_state == CAPTURE) && (w_count_next == CW'(DEPTH));

    assign w_we    = (r_state == ARMED && w_hit) || (r_state == CAPTURE);
    assign w_waddr = (r_state == ARMED) ? '0 : r_count[AW-1:0];

    // Issue a read on DONE entry, then prefetch the next address on every handshake.
    assign w_re = (r_state == DONE) && !abort && !arm &&
                  (!r_rd_valid || (rd_ready && !w_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        if (abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (arm) w_next = ARMED;
                ARMED:   if (w_hit) w_next = CAPTURE;
                CAPTURE: if (w_cap_end) w_next = DONE;
                DONE: begin
                    if (arm) begin
                        w_next = ARMED;
                    end else if (w_hs && w_last) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
        busy = (r_state == ARMED) || (r_state == CAPTURE);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_rd_idx   <= '0;
            r_rd_valid <= 1'b0;
        end else if (abort) begin
            r_rd_valid <= 1'b0;
        end else if (w_arm_ok) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_state)
                ARMED: begin
                    if (w_hit) r_count <= CW'(1);
                end
                CAPTURE: begin
                    r_count <= w_count_next;
                end
                DONE: begin
                    if (w_re) begin
                        r_rd_ptr   <= r_rd_ptr + AW'(1);
                        r_rd_idx   <= r_rd_ptr;
                        r_rd_valid <= 1'b1;
                    end else if (w_hs && w_last) begin
                        r_rd_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    la_capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (la_dat),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_q)
    );

    assign state    = r_state;
    assign rd_valid = r_rd_valid;
    assign rd_last  = w_last;
    assign rd_data  = r_rd_valid ? w_mem_q : '0;

`ifdef LA_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] r_cycle;
    logic [TS_W-1:0] r_trig_time;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle     <= '0;
            r_trig_time <= '0;
        end else begin
            r_cycle <= r_cycle + TS_W'(1);
            if (!abort && r_state == ARMED && w_hit) begin
                r_trig_time <= r_cycle;
            end
        end
    end

    assign trig_time = r_trig_time;
`else
    assign trig_time = '0;
`endif

endmodule

// File: tb/tb_la_capture.sv
// Self-checking bench for la_capture: vector table plus randomized captures
// scored against a queue-based model of the capture window.
module tb_la_capture;
    import la_capture_pkg::*;

    localparam int W = 128;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  la_dat;
    logic          arm;
    logic          abort;
    logic [W-1:0]  trig_mask;
    logic [W-1:0]  trig_value;
    logic          busy;
    logic          done;
    cap_state_t    state;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic          rd_last;
    logic [31:0]   trig_time;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int expTrig = 0;
    logic [W-1:0] expQ[$];

    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] value;
        int           mode;
        int           readyMode;
        int           firstLow;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    la_capture #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .la_dat     (la_dat),
        .arm        (arm),
        .abort      (abort),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .busy       (busy),
        .done       (done),
        .state      (state),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .trig_time  (trig_time)
    );

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic armV, input logic abortV,
                                 input logic readyV, input logic [W-1:0] datV);
        arm      = armV;
        abort    = abortV;
        rd_ready = readyV;
        la_dat   = datV;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [W-1:0] genDat(input int mode);
        logic [W-1:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (mode == 0) v = W'(cyc);
        else if (mode == 1) v[7:0] = 8'(cyc);
        return v;
    endfunction

    task automatic doReset();
        rst        = 1'b1;
        trig_mask  = '0;
        trig_value = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    // Model: the first ARMED cycle whose la_dat matches opens a window of D
    // consecutive samples; the readout must return exactly that window in order.
    task automatic runCapture(input logic [W-1:0] mask, input logic [W-1:0] val,
                              input int mode, input int readyMode, input int firstLow);
        int got = 0;
        int guard = 0;
        int idx = 0;
        int waitCyc = 0;
        logic stalled = 1'b0;
        logic lastHeld = 1'b0;
        logic [W-1:0] held = '0;
        expQ.delete();
        trig_mask  = mask;
        trig_value = val;
        applyStimulus(1'b1, 1'b0, 1'b0, genDat(mode));
        step();
        arm = 1'b0;
        while (got < D && guard < 600) begin
            la_dat = genDat(mode);
            if (guard == 0) begin
                @(negedge clk);
                checkOutput("armed_state", W'(state), W'(ARMED));
                checkOutput("armed_busy", W'(busy), W'(1));
            end
            if (got > 0 || (((la_dat ^ val) & mask) == '0)) begin
                if (got == 0) expTrig = cyc;
                expQ.push_back(la_dat);
                got++;
            end
            step();
            guard++;
        end
        if (got < D) begin
            checkOutput("trigger_timeout", W'(got), W'(D));
            return;
        end
        la_dat = genDat(2);
        @(negedge clk);
        checkOutput("done_state", W'(state), W'(DONE));
        checkOutput("done_flag", W'(done), W'(1));
        checkOutput("valid_at_done_entry", W'(rd_valid), W'(0));
`ifdef LA_CAPTURE_TIMESTAMP_EN
        checkOutput("trig_time", W'(trig_time), W'(expTrig));
`else
        checkOutput("trig_time", W'(trig_time), W'(0));
`endif
        step();
        while (idx < D && waitCyc < 200) begin
            if (readyMode == 0) rd_ready = 1'b1;
            else if (readyMode == 1) rd_ready = (waitCyc % 2 == 0);
            else rd_ready = 1'($urandom_range(0, 1));
            la_dat = genDat(2);
            @(negedge clk);
            if (waitCyc == 0) checkOutput("valid_latency", W'(rd_valid), W'(1));
            if (stalled) begin
                checkOutput("stall_valid", W'(rd_valid), W'(1));
                checkOutput("stall_data", rd_data, held);
                checkOutput("stall_last", W'(rd_last), W'(lastHeld));
            end
            if (rd_valid && rd_ready) begin
                checkOutput("rd_data", rd_data, expQ.pop_front());
                checkOutput("rd_last", W'(rd_last), W'(idx == D - 1));
                if (firstLow >= 0) checkOutput("low_byte", W'(rd_data[7:0]), W'(8'(firstLow + idx)));
                idx++;
                stalled = 1'b0;
            end else begin
                stalled  = rd_valid;
                held     = rd_data;
                lastHeld = rd_last;
            end
            step();
            waitCyc++;
        end
        rd_ready = 1'b0;
        if (idx < D) checkOutput("readout_timeout", W'(idx), W'(D));
        @(negedge clk);
        checkOutput("end_idle", W'(state), W'(IDLE));
        checkOutput("end_valid", W'(rd_valid), W'(0));
    endtask

    // Arm with mask 0 and advance until the first readout word is presented.
    task automatic fillToValid();
        trig_mask = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, genDat(2));
        step();
        arm = 1'b0;
        for (int i = 0; i < D + 1; i++) begin
            la_dat = genDat(2);
            step();
        end
    endtask

    initial begin
        int seen;
        int nRand;

        doReset();
        @(negedge clk);
        checkOutput("rst_state", W'(state), W'(IDLE));
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_done", W'(done), W'(0));
        checkOutput("rst_valid", W'(rd_valid), W'(0));
        checkOutput("rst_last", W'(rd_last), W'(0));
        checkOutput("rst_data", rd_data, '0);
        checkOutput("rst_trig_time", W'(trig_time), W'(0));

        // Timestamp: arm in counter cycle 99 so the ARMED (trigger) cycle is 100.
        while (cyc < 99) step();
        runCapture('0, '0, 0, 0, -1);
`ifdef LA_CAPTURE_TIMESTAMP_EN
        checkOutput("trig_time_100", W'(trig_time), W'(100));
`else
        checkOutput("trig_time_off", W'(trig_time), W'(0));
`endif

        vecs[0] = '{mask: '0,             value: '0,            mode: 0, readyMode: 0, firstLow: -1};
        vecs[1] = '{mask: W'(8'hFF),      value: W'(8'h5A),     mode: 1, readyMode: 0, firstLow: 8'h5A};
        vecs[2] = '{mask: '0,             value: '0,            mode: 2, readyMode: 1, firstLow: -1};
        vecs[3] = '{mask: W'(4'hF),       value: W'(4'h9),      mode: 2, readyMode: 2, firstLow: -1};
        vecs[4] = '{mask: W'(1) << 100,   value: W'(1) << 100,  mode: 2, readyMode: 1, firstLow: -1};
        for (int v = 0; v < 5; v++) begin
            runCapture(vecs[v].mask, vecs[v].value, vecs[v].mode, vecs[v].readyMode, vecs[v].firstLow);
        end

        for (int r = 0; r < 4; r++) begin
            logic [W-1:0] m;
            m = '0;
            nRand = $urandom_range(1, 4);
            for (int b = 0; b < nRand; b++) m[$urandom_range(0, W - 1)] = 1'b1;
            runCapture(m, genDat(2), 2, 2, -1);
        end

        // Abort after the trigger sample plus 5 CAPTURE samples.
        trig_mask = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, genDat(2));
        step();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            la_dat = genDat(2);
            step();
        end
        @(negedge clk);
        checkOutput("pre_abort_state", W'(state), W'(CAPTURE));
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_state", W'(state), W'(IDLE));
        checkOutput("abort_busy", W'(busy), W'(0));
        seen = 0;
        rd_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rd_valid) seen++;
            step();
        end
        rd_ready = 1'b0;
        checkOutput("abort_no_valid", W'(seen), W'(0));

        applyStimulus(1'b1, 1'b1, 1'b0, genDat(2));
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, genDat(2));
        @(negedge clk);
        checkOutput("arm_abort_state", W'(state), W'(IDLE));

        // arm while a readout is pending discards the buffer.
        fillToValid();
        @(negedge clk);
        checkOutput("pending_valid", W'(rd_valid), W'(1));
        arm = 1'b1;
        step();
        arm = 1'b0;
        @(negedge clk);
        checkOutput("rearm_state", W'(state), W'(ARMED));
        checkOutput("rearm_valid", W'(rd_valid), W'(0));
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Reset during readout returns everything to reset values.
        fillToValid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        @(negedge clk);
        checkOutput("midrst_state", W'(state), W'(IDLE));
        checkOutput("midrst_valid", W'(rd_valid), W'(0));
        checkOutput("midrst_last", W'(rd_last), W'(0));
        checkOutput("midrst_data", rd_data, '0);
        checkOutput("midrst_trig_time", W'(trig_time), W'(0));

        runCapture('0, '0, 2, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
